// File: rtl/cube_sort_pkg.sv
// cube_sort_pkg: node constants and feeder state shared with the cube sorter.
package cube_sort_pkg;
    localparam int NODES_DEF = 16;
    localparam int WIDTH_DEF = 16;
    localparam logic [WIDTH_DEF-1:0] PAD_VALUE = '1;
    typedef enum logic {FILL, PRESENT} state_t;
endpackage

// File: rtl/cube_sort_feeder_if.sv
// cube_sort_feeder_if: word stream in, parallel frame bus out.
interface cube_sort_feeder_if
    import cube_sort_pkg::*;
#(
    parameter int NODES = NODES_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
);
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    in_last;
    logic                    in_ready;
    logic [NODES*WIDTH-1:0]  frame_data;
    logic                    frame_valid;
    logic [CNT_W-1:0]        frame_count;
    logic [$clog2(NODES):0]  fill_level;
    modport master (output in_valid, in_data, in_last,
                    input  in_ready, frame_data, frame_valid, frame_count, fill_level);
    modport slave  (input  in_valid, in_data, in_last,
                    output in_ready, frame_data, frame_valid, frame_count, fill_level);
endinterface

// File: rtl/cube_sort_feeder.sv
// cube_sort_feeder: assembles NODES-word frames and holds them for the sorter.
// FEEDER_PAD_EN: in_last closes a short frame, padding the rest with PAD_VALUE.
module cube_sort_feeder
    import cube_sort_pkg::*;
#(
    parameter int NODES       = NODES_DEF,
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input logic clk,
    input logic rst_n,
    cube_sort_feeder_if.slave bus
);
    localparam int IW = $clog2(NODES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [WIDTH-1:0] PAD = {WIDTH{&PAD_VALUE}};
    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [HW-1:0]          hold_q;
    logic [WIDTH-1:0]       buf_q [NODES];
    logic [NODES*WIDTH-1:0] frame_q, frame_d;
    logic                   fv_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   acc, last, launch;
    assign acc = bus.in_valid && state_q == FILL;
`ifdef FEEDER_PAD_EN
    assign last = bus.in_last;
`else
    assign last = 1'b0;
`endif
    assign launch = acc && (last || idx_q == IW'(NODES - 1));
    // Frame as it will be once the current word lands; slots past it pad on an early last.
    always_comb begin
        for (int k = 0; k < NODES; k++)
            frame_d[k*WIDTH +: WIDTH] = k == int'(idx_q) ? bus.in_data :
                                        (last && k > int'(idx_q)) ? PAD : buf_q[k];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            hold_q  <= '0;
            frame_q <= '0;
            fv_q    <= 1'b0;
            cnt_q   <= '0;
            for (int k = 0; k < NODES; k++) buf_q[k] <= '0;
        end else begin
            if (acc) begin
                buf_q[idx_q[IW-2:0]] <= bus.in_data;
                idx_q <= launch ? '0 : idx_q + 1'b1;
            end
            if (launch) begin
                frame_q <= frame_d;
                fv_q    <= 1'b1;
                state_q <= PRESENT;
                hold_q  <= HW'(HOLD_CYCLES - 1);
                cnt_q   <= cnt_q + 1'b1;
            end else if (state_q == PRESENT) begin
                if (hold_q == '0) begin
                    state_q <= FILL;
                    fv_q    <= 1'b0;
                end else begin
                    hold_q <= hold_q - 1'b1;
                end
            end
        end
    end
    assign bus.in_ready    = state_q == FILL;
    assign bus.frame_data  = frame_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_count = cnt_q;
    assign bus.fill_level  = idx_q;
endmodule
